// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, constants and types for the register file
//
// Purpose : single source for the register-file default geometry, the index of
//           the hardwired zero register, and the address/data typedefs used by
//           register_file, Register and any block that talks to them.
// Contents:
//   DATA_WIDTH  default register / data-port width (32)
//   ADDR_WIDTH  default register-address width (5)
//   NUM_REGS    default entry count (2**ADDR_WIDTH)
//   ZERO_REG    index of the hardwired-zero entry (0)
//   reg_addr_t  register index type
//   reg_data_t  register contents type
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int ZERO_REG   = 0;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/Register.sv
// rtl/Register.sv - single storage cell with load enable and async clear
//
// Purpose : one architectural register entry. Loads writeToReg on the rising
//           clock edge when enable is high; holds otherwise. An asserted reset
//           clears the contents immediately, independent of clk.
// Parameters:
//   WIDTH       cell width (defaults to the package data width, 32)
// Ports:
//   writeToReg  in   WIDTH  value to load
//   enable      in   1      load enable, sampled on the rising edge of clk
//   clk         in   1      clock
//   reset       in   1      asynchronous, active-high clear
//   data        out  WIDTH  current contents
module Register #(
    parameter int WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic [WIDTH-1:0] writeToReg,
    input  logic             enable,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Hold unless enabled; the clear path lives in the flop itself.
    always_comb begin
        data_d = data_q;
        if (enable) begin
            data_d = writeToReg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule : Register

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file, 2 combinational reads, 1 clocked write
//
// Purpose : NUM_REGS general-purpose registers for the datapath. Entry 0 has no
//           storage and always reads zero. Entries 1..NUM_REGS-1 are Register
//           cells; the write decoder and both read muxes live here.
// Optional feature (macro REGFILE_BYPASS_EN):
//           defined   - each read port returns writeData in the same cycle when
//                       it names the (non-zero) register being written.
//           undefined - reads reflect stored contents only.
//           In both builds an asserted reset forces both read ports to zero.
// Parameters:
//   DATA_WIDTH  register and data-port width (32)
//   ADDR_WIDTH  register-address width (5)
//   NUM_REGS    entry count, must equal 2**ADDR_WIDTH
// Ports:
//   clk        in   1           clock, all writes on its rising edge
//   reset      in   1           asynchronous, active-high clear of every entry
//   regWrite   in   1           write enable
//   writeReg   in   ADDR_WIDTH  destination index
//   writeData  in   DATA_WIDTH  value to store
//   readReg1   in   ADDR_WIDTH  source index, port 1
//   readReg2   in   ADDR_WIDTH  source index, port 2
//   readData1  out  DATA_WIDTH  contents of readReg1
//   readData2  out  DATA_WIDTH  contents of readReg2
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    // Stored values, indexed directly by the read addresses. Entry 0 is a
    // constant so the read mux needs no special case for it.
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    assign regs_q[0] = '0;

    // One cell per real entry. The decode compare is per entry, so at most one
    // enable can be high in any cycle and index 0 never produces one.
    for (genvar k = 1; k < NUM_REGS; k++) begin : g_entry
        logic wr_en;

        assign wr_en = regWrite && (writeReg == ADDR_WIDTH'(k));

        Register #(
            .WIDTH (DATA_WIDTH)
        ) u_reg (
            .writeToReg (writeData),
            .enable     (wr_en),
            .clk        (clk),
            .reset      (reset),
            .data       (regs_q[k])
        );
    end

    logic [DATA_WIDTH-1:0] rd1_d;
    logic [DATA_WIDTH-1:0] rd2_d;

`ifdef REGFILE_BYPASS_EN
    // Write-through: a read of the register being written this cycle sees the
    // incoming value before the edge. Index 0 is excluded so it stays zero.
    logic byp1;
    logic byp2;

    assign byp1 = regWrite && (writeReg != ZERO_IDX) && (writeReg == readReg1);
    assign byp2 = regWrite && (writeReg != ZERO_IDX) && (writeReg == readReg2);

    always_comb begin
        rd1_d = regs_q[readReg1];
        rd2_d = regs_q[readReg2];
        if (byp1) begin
            rd1_d = writeData;
        end
        if (byp2) begin
            rd2_d = writeData;
        end
    end
`else
    always_comb begin
        rd1_d = regs_q[readReg1];
        rd2_d = regs_q[readReg2];
    end
`endif

    // Storage is already clear while reset is high; the gate also keeps any
    // write-through value off the outputs during reset.
    assign readData1 = reset ? '0 : rd1_d;
    assign readData2 = reset ? '0 : rd2_d;

endmodule : register_file

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file (default and REGFILE_BYPASS_EN builds)
module tb_register_file;
    import regfile_pkg::*;

    logic      clk;
    logic      reset;
    logic      regWrite;
    reg_addr_t writeReg;
    reg_data_t writeData;
    reg_addr_t readReg1;
    reg_addr_t readReg2;
    reg_data_t readData1;
    reg_data_t readData2;

    int n_checks;
    int n_fail;

    typedef struct {
        string     tag;
        reg_data_t exp;
    } sb_item_t;

    sb_item_t  sb[$];
    reg_data_t model [NUM_REGS];

    register_file dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input reg_data_t obs, input reg_data_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic reg_data_t model_rd(input reg_addr_t a);
        return (a == reg_addr_t'(ZERO_REG)) ? '0 : model[a];
    endfunction

    // Push expectations, present the addresses, then pop and compare once the
    // combinational outputs have settled.
    task automatic read_check(input string tag, input reg_addr_t a1, input reg_addr_t a2,
                              input reg_data_t e1, input reg_data_t e2);
        sb_item_t it;
        sb.push_back('{tag: {tag, "_rd1"}, exp: e1});
        sb.push_back('{tag: {tag, "_rd2"}, exp: e2});
        readReg1 = a1;
        readReg2 = a2;
        #1;
        it = sb.pop_front();
        check_val(it.tag, readData1, it.exp);
        it = sb.pop_front();
        check_val(it.tag, readData2, it.exp);
    endtask

    task automatic read_model(input string tag, input reg_addr_t a1, input reg_addr_t a2);
        read_check(tag, a1, a2, model_rd(a1), model_rd(a2));
    endtask

    task automatic wr(input reg_addr_t a, input reg_data_t d);
        @(negedge clk);
        regWrite  = 1'b1;
        writeReg  = a;
        writeData = d;
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        if (a != reg_addr_t'(ZERO_REG)) model[a] = d;
    endtask

    initial begin
        reg_data_t same_exp;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        // Reset held with a write pending: reset wins, reads are zero.
        reset     = 1'b1;
        regWrite  = 1'b1;
        writeReg  = 5'd3;
        writeData = 32'hFFFF_FFFF;
        readReg1  = 5'd3;
        readReg2  = 5'd0;
        #18;
        read_check("reset_hold", 5'd3, 5'd3, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        model[3] = 32'hFFFF_FFFF;
        read_model("first_write", 5'd3, 5'd0);

        // Basic writes on consecutive edges.
        wr(5'd1, 32'd5);
        wr(5'd2, 32'd15);
        wr(5'd31, 32'd25);
        read_check("basic", 5'd2, 5'd31, 32'd15, 32'd25);
        read_check("basic_r1", 5'd1, 5'd1, 32'd5, 32'd5);

        // Writes to r0 are discarded.
        wr(5'd0, 32'hDEAD_BEEF);
        read_check("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);
        read_model("zero_side", 5'd1, 5'd31);

        // Hold with regWrite low.
        wr(5'd7, 32'h1234);
        @(negedge clk);
        regWrite  = 1'b0;
        writeReg  = 5'd7;
        writeData = 32'h9999;
        @(posedge clk);
        @(posedge clk);
        #1;
        read_check("hold", 5'd7, 5'd3, 32'h1234, 32'hFFFF_FFFF);

        // Same-cycle read of the write target.
        wr(5'd4, 32'd10);
        @(negedge clk);
        regWrite  = 1'b1;
        writeReg  = 5'd4;
        writeData = 32'd20;
`ifdef REGFILE_BYPASS_EN
        same_exp = 32'd20;
`else
        same_exp = 32'd10;
`endif
        read_check("same_cycle", 5'd4, 5'd4, same_exp, same_exp);
        read_check("same_other", 5'd4, 5'd2, same_exp, 32'd15);
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        model[4] = 32'd20;
        read_model("after_edge", 5'd4, 5'd4);

        // Writing r0 while reading r0: never a bypass.
        @(negedge clk);
        regWrite  = 1'b1;
        writeReg  = 5'd0;
        writeData = 32'hA5A5_A5A5;
        read_check("zero_bypass", 5'd0, 5'd0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        read_check("zero_after", 5'd0, 5'd1, 32'h0, 32'd5);

        // Random write/read traffic against the model.
        for (int i = 0; i < 20; i++) begin
            reg_addr_t a;
            a = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            wr(a, reg_data_t'($urandom));
            read_model("rand", a, reg_addr_t'($urandom_range(0, NUM_REGS - 1)));
        end

        // Async reset pulse between edges.
        wr(5'd1, 32'h11);
        wr(5'd2, 32'h22);
        wr(5'd3, 32'h33);
        wr(5'd4, 32'h44);
        read_check("pre_reset", 5'd1, 5'd4, 32'h11, 32'h44);
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        read_check("async_rst_a", 5'd1, 5'd2, 32'h0, 32'h0);
        read_check("async_rst_b", 5'd3, 5'd4, 32'h0, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        read_check("post_reset", 5'd1, 5'd4, 32'h0, 32'h0);
        read_model("post_reset_r31", 5'd31, 5'd7);
        wr(5'd9, 32'hCAFE_F00D);
        read_check("post_reset_wr", 5'd9, 5'd1, 32'hCAFE_F00D, 32'h0);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file
